// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 32/16 signed divider.
package div_pkg;
    localparam int DIV_W     = 16;
    localparam int CNT_W     = 5;
    localparam int DIV_STEPS = 16;
    localparam logic [DIV_W-1:0] Q_ERR = 16'h8000;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/seq_div32by16_if.sv
// Start/busy/done handshake and data bus of the divider.
interface seq_div32by16_if;
    import div_pkg::*;
    logic                 start;
    logic [2*DIV_W-1:0]   dividend;
    logic [DIV_W-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [DIV_W-1:0]     quotient;
    logic [DIV_W-1:0]     remainder;
    logic                 ovf;
    logic                 dz;

    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder, ovf, dz);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder, ovf, dz);
endinterface

// File: rtl/div_restore_step.sv
// One radix-2 restoring step: shift {R,Q} left, trial-subtract |divisor|, keep if non-negative.
module div_restore_step
    import div_pkg::*;
(
    input  logic [DIV_W:0]   r_i,
    input  logic [DIV_W-1:0] q_i,
    input  logic [DIV_W-1:0] d_i,
    output logic [DIV_W:0]   r_o,
    output logic [DIV_W-1:0] q_o
);
    logic [DIV_W:0]   r_sh;
    logic [DIV_W+1:0] t;

    // R stays below 2^16 in every meaningful run, so the dropped top bit is zero
    assign r_sh = {r_i[DIV_W-1:0], q_i[DIV_W-1]};
    assign t    = {1'b0, r_sh} - {2'b00, d_i};

    always_comb begin
        r_o = r_sh;
        q_o = {q_i[DIV_W-2:0], 1'b0};
        if (!t[DIV_W+1]) begin
            r_o    = t[DIV_W:0];
            q_o[0] = 1'b1;
        end
    end
endmodule

// File: rtl/seq_div32by16.sv
// Sequential signed 32/16 divider: sign/magnitude front end, 16 restoring steps, sign fix-up.
module seq_div32by16
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    seq_div32by16_if.slave   bus
);
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W:0]       r_q, r_d, r_nx;
    logic [DIV_W-1:0]     q_q, q_d, q_nx;
    logic [DIV_W-1:0]     dabs_q, dabs_d;
    logic                 sgnq_q, sgnq_d, sgnr_q, sgnr_d;
    logic                 dzp_q, dzp_d, ovfp_q, ovfp_d;
    logic [DIV_W-1:0]     quot_q, quot_d, rem_q, rem_d;
    logic                 ovf_q, ovf_d, dz_q, dz_d, done_q, done_d;
    logic [2*DIV_W-1:0]   dvd_abs;
    logic [DIV_W-1:0]     dvs_abs;
    logic                 ovf_final;

    assign dvd_abs = bus.dividend[2*DIV_W-1] ? (~bus.dividend + 32'd1) : bus.dividend;
    assign dvs_abs = bus.divisor[DIV_W-1]    ? (~bus.divisor  + 16'd1) : bus.divisor;

    div_restore_step u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (dabs_q),
        .r_o (r_nx),
        .q_o (q_nx)
    );

    // A negative quotient may reach magnitude 2^15, a positive one only 2^15-1
    assign ovf_final = ovfp_q | (!sgnq_q && q_q[DIV_W-1]) | (sgnq_q && (q_q > Q_ERR));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dabs_d  = dabs_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        dzp_d   = dzp_q;
        ovfp_d  = ovfp_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                dabs_d  = dvs_abs;
                sgnq_d  = bus.dividend[2*DIV_W-1] ^ bus.divisor[DIV_W-1];
                sgnr_d  = bus.dividend[2*DIV_W-1];
                r_d     = {1'b0, dvd_abs[2*DIV_W-1:DIV_W]};
                q_d     = dvd_abs[DIV_W-1:0];
                cnt_d   = '0;
                dzp_d   = (bus.divisor == '0);
                ovfp_d  = (bus.divisor != '0) && (dvd_abs[2*DIV_W-1:DIV_W] >= dvs_abs);
                state_d = RUN;
            end
            RUN: begin
                r_d   = r_nx;
                q_d   = q_nx;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_W'(DIV_STEPS-1)) state_d = FIX;
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dzp_q || ovf_final) begin
                    quot_d = Q_ERR;
                    rem_d  = '0;
                    dz_d   = dzp_q;
                    ovf_d  = !dzp_q;
                end else begin
                    quot_d = sgnq_q ? (~q_q + 16'd1) : q_q;
                    rem_d  = sgnr_q ? (~r_q[DIV_W-1:0] + 16'd1) : r_q[DIV_W-1:0];
                    dz_d   = 1'b0;
                    ovf_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dabs_q  <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            dzp_q   <= 1'b0;
            ovfp_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dabs_q  <= dabs_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            dzp_q   <= dzp_d;
            ovfp_q  <= ovfp_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.ovf       = ovf_q;
    assign bus.dz        = dz_q;
endmodule

// File: tb/tb_seq_div32by16.sv
// Scoreboard bench for seq_div32by16: integer reference model, queue of expectations, done-driven monitor.
module tb_seq_div32by16;
    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        ovf;
        logic        dz;
        int          e0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    seq_div32by16_if bus();
    seq_div32by16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain signed integer division with truncation toward zero
    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
        exp_t e;
        longint sa, sb_, qq, rr;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        e.e0 = 0;
        e.ovf = 1'b0;
        e.dz = 1'b0;
        if (sb_ == 0) begin
            e.dz = 1'b1; e.q = 16'h8000; e.r = 16'h0000;
        end else begin
            qq = sa / sb_;
            rr = sa % sb_;
            if (qq > 32767 || qq < -32768) begin
                e.ovf = 1'b1; e.q = 16'h8000; e.r = 16'h0000;
            end else begin
                e.q = qq[15:0]; e.r = rr[15:0];
            end
        end
        return e;
    endfunction

    // Waits (bounded) for IDLE, then issues one accepted request and records its expectation
    task automatic do_op(input logic [31:0] a, input logic [15:0] b);
        exp_t e;
        int   t;
        t = 0;
        while (bus.busy === 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) check("idle_timeout", 32'd1, 32'd0);
        e = model(a, b);
        e.e0 = cyc + 1;
        sb.push_back(e);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = 16'($urandom);
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", sb.size(), 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("quotient",  {16'd0, bus.quotient},  {16'd0, e.q});
                check("remainder", {16'd0, bus.remainder}, {16'd0, e.r});
                check("ovf",       {31'd0, bus.ovf},       {31'd0, e.ovf});
                check("dz",        {31'd0, bus.dz},        {31'd0, e.dz});
                check("latency",   cyc - e.e0,             32'd17);
                check("busy_in_done", {31'd0, bus.busy},   32'd0);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [15:0] b;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_q",    {16'd0, bus.quotient}, 32'd0);
        check("rst_r",    {16'd0, bus.remainder}, 32'd0);
        check("rst_flags", {30'd0, bus.ovf, bus.dz}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'd12, 16'd4);
        do_op(32'h0878_4983, 16'hBEEF);
        do_op(32'd4851, 16'd63);
        do_op(32'hFFFF_FFF9, 16'd2);
        do_op(32'h0000_8000, 16'hFFFF);
        do_op(32'h0000_8000, 16'd1);
        do_op(32'h0001_0000, 16'd1);
        do_op(32'd100, 16'd0);
        do_op(32'h8000_0000, 16'hFFFF);
        do_op(32'h8000_0000, 16'h8000);
        do_op(32'hFFFF_8000, 16'h0001);
        drain();

        // start pulses while busy must be ignored
        do_op(32'd1000, 16'd7);
        repeat (4) @(negedge clk);
        bus.dividend = 32'd55; bus.divisor = 16'd5; bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        check("no_extra_done", sb.size(), 32'd0);

        // random mix, back-to-back
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = 16'($urandom); end
                1: begin
                    b = 16'($urandom);
                    a = 32'($signed(16'($urandom)) * $signed(b)) + 32'($signed(16'($urandom_range(0, 200)) - 16'd100));
                end
                2: begin a = 32'($signed(16'($urandom))); b = 16'($urandom_range(1, 300)); end
                default: begin a = $urandom; b = ($urandom_range(0, 1) == 1) ? 16'd0 : 16'hFFFF; end
            endcase
            do_op(a, b);
        end
        drain();

        // reset in the middle of RUN aborts the operation
        bus.dividend = 32'd999; bus.divisor = 16'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_q",    {16'd0, bus.quotient}, 32'd0);
        check("abort_r",    {16'd0, bus.remainder}, 32'd0);
        check("abort_flags", {30'd0, bus.ovf, bus.dz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_no_done_q", {16'd0, bus.quotient}, 32'd0);
        check("abort_sb_empty", sb.size(), 32'd0);

        do_op(32'hFFFF_FF00, 16'd16);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, limit reached");
        $fatal(1, "timeout");
    end
endmodule
